rx_flow_state_ctrl: RTL
=======================

# rx_flow_state_ctrl

Sequences per-flow receive-side bookkeeping in the TCP slow path. For each arriving data-packet descriptor, it:
- reads the flow's RX state word;
- decides whether a payload buffer is needed and requests it from the RX payload allocator;
- computes the next ACK number, RX ring tail index and advertised window;
- writes the state back and hands the result to the ACK/TX-metadata stage.

It also arbitrates the single state-memory write port between packet updates and application head-index (consume) updates.

## Interface
Parameters:
- FLOWID_W, default FLOWID_W from tcp_pkg: flow identifier width
- RX_PAYLOAD_IDX_W, default from tcp_pkg: log2 of RX ring entries per flow
- RX_PAYLOAD_PTR_W, default from tcp_pkg: log2 of RX payload buffer bytes

Ports:
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- pkt_req_val / pkt_req_rdy  in / out  1 / 1  packet descriptor handshake
- pkt_req_flowid  in  FLOWID_W  flow of the packet
- pkt_req_seq_num  in  `SEQ_NUM_W  sequence number of the packet
- pkt_req_payload_len  in  PAYLOAD_ENTRY_LEN_W  payload length of the packet
- app_head_val / app_head_rdy  in / out  1 / 1  application consume update handshake
- app_head_flowid  in  FLOWID_W  flow being consumed
- app_head_idx  in  RX_PAYLOAD_IDX_W+1  new head index
- state_rd_req_val  out  1  state memory read request
- state_rd_req_flowid  out  FLOWID_W  flow to read
- state_rd_resp_data  in  rx_flow_state_struct  read data, valid exactly one cycle after the request
- state_wr_val  out  1  state memory write strobe
- state_wr_flowid  out  FLOWID_W  flow to write
- state_wr_data  out  rx_flow_state_struct  write data
- state_wr_head_only  out  1  qualifies a head-only write
- malloc_req_val / malloc_req_rdy  out / in  1 / 1  buffer request handshake
- malloc_req_len  out  PAYLOAD_ENTRY_LEN_W  requested buffer length
- malloc_resp_val / malloc_resp_rdy  in / out  1 / 1  allocator response handshake
- malloc_resp_success  in  1  allocation succeeded
- malloc_resp_approx_space  in  RX_PAYLOAD_PTR_W+1  approximate free buffer space
- result_val / result_rdy  out / in  1 / 1  result handshake
- result_flowid  out  FLOWID_W  flow of the result
- result_accept  out  1  payload accepted
- result_ack_num  out  `ACK_NUM_W  ACK number to send
- result_our_win  out  RX_PAYLOAD_PTR_W+1  advertised window

## Operation
- FSM states: IDLE → RD → DECIDE → (WAIT_MALLOC) → WR → OUT → IDLE.
- IDLE:
  - pkt_req_rdy=1 unless app_head_val=1. The application update has priority.
  - An app update in IDLE or OUT issues a head-only write (state_wr_val=1, state_wr_head_only=1) in the same cycle, with app_head_rdy=1.
  - app_head_rdy=0 in every other state.
- RD: drives state_rd_req_val=1 with the latched flowid.
- DECIDE: latches the state word, then computes:
  - used = tail − head (IDX_W+1 bits, modulo arithmetic)
  - full = (used == 2^IDX_W)
  - match = (seq == ack_num)
  - If match & !full & len≠0: holds malloc_req_val until malloc_req_rdy, then goes to WAIT_MALLOC.
  - Otherwise: no malloc; success=0, space=stored last_win; goes to WR.
- WAIT_MALLOC: malloc_resp_rdy=1; captures success and space on malloc_resp_val.
- WR, via sub-module rx_ack_calc:
  - accept = match & !full & success
  - On accept: ack = seq+len (mod 2^32); tail = tail+1 (wraps); win = space − len, saturating at 0.
  - Otherwise: ack, tail and win are unchanged (window = space, or last_win if no malloc).
  - Full-word write (state_wr_head_only=0) of the updated state word.
  - result_val=1.
- OUT: holds the result until result_rdy, then returns to IDLE.
  - result_val is also asserted in WR. If result_rdy=1 in WR, the FSM goes directly to IDLE.
- An app update for the in-flight flow in OUT is permitted: WR has already committed.

## Timing
- Reset values: pkt_req_rdy=0, app_head_rdy=0, all *_val outputs 0, malloc_resp_rdy=0, result fields 0; FSM=IDLE. pkt_req_rdy rises on the first cycle after rst deasserts.
- rst asserted mid-operation: returns to IDLE next cycle. No write is issued and any outstanding malloc response is discarded (the allocator is reset by the same rst).
- Latency:
  - Accept at cycle N → RD at N+1 → DECIDE at N+2.
  - No-malloc path: WR/result_val at N+3.
  - Malloc path: result_val at the first cycle after malloc_resp_val.
- Throughput: at most one packet per 4 cycles.
- State write and app head write are never in the same cycle.

## Structure
- tcp_pkg contents:
  - rx_flow_state_struct: {ack_num `ACK_NUM_W, head IDX_W+1, tail IDX_W+1, last_win PTR_W+1}
  - FSM state enum
- One sub-module, rx_ack_calc: pure combinational accept/ACK/tail/window computation.
- Datapath registers and FSM live in rx_flow_state_ctrl.

## Test plan
- In-order packet: ack=1000, head=tail=0, seq=1000, len=200, malloc success, space=4000 → accept=1, ack=1200, tail=1, win=3800, result at malloc_resp+1.
- Out-of-order: seq=1500 vs ack=1200 → no malloc_req_val; accept=0, ack=1200, win=last_win, result at N+3.
- Ring full: tail−head=2^IDX_W, including tail wrap 0x1F→0x00 → no malloc, accept=0; with success, the tail wraps correctly.
- Malloc failure and saturation:
  - success=0 → accept=0, win=space;
  - success=1, space=100, len=200 → win=0.
- Arbitration:
  - app_head_val and pkt_req_val in the same IDLE cycle → head-only write first, packet accepted next cycle.
  - app update during WAIT_MALLOC is stalled.
- Backpressure and reset:
  - result_rdy held 0 for 5 cycles → result fields stable, no second state write.
  - rst pulse during WAIT_MALLOC → all valids 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/tcp_pkg.sv
// Shared widths, RX flow state word and controller FSM encoding
// for the TCP slow-path receive bookkeeping blocks.
package tcp_pkg;

    localparam int FLOWID_W            = 8;
    localparam int RX_PAYLOAD_IDX_W    = 4;
    localparam int RX_PAYLOAD_PTR_W    = 14;
    localparam int PAYLOAD_ENTRY_LEN_W = 16;
    localparam int SEQ_NUM_W           = 32;
    localparam int ACK_NUM_W           = 32;

    typedef struct packed {
        logic [ACK_NUM_W-1:0]      ack_num;
        logic [RX_PAYLOAD_IDX_W:0] head;
        logic [RX_PAYLOAD_IDX_W:0] tail;
        logic [RX_PAYLOAD_PTR_W:0] last_win;
    } rx_flow_state_struct;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_DECIDE,
        ST_WAIT_MALLOC,
        ST_WR,
        ST_OUT
    } rx_state_e;

endpackage

// File: rtl/rx_flow_state_ctrl_if.sv
// Bundle of all handshake/bus signals of rx_flow_state_ctrl.
// slave: controller side; master: packet source, app, memory, allocator, sink.
interface rx_flow_state_ctrl_if #(
    parameter int FLOWID_W         = tcp_pkg::FLOWID_W,
    parameter int RX_PAYLOAD_IDX_W = tcp_pkg::RX_PAYLOAD_IDX_W,
    parameter int RX_PAYLOAD_PTR_W = tcp_pkg::RX_PAYLOAD_PTR_W
) ();
    import tcp_pkg::*;

    logic                           pkt_req_val;
    logic                           pkt_req_rdy;
    logic [FLOWID_W-1:0]            pkt_req_flowid;
    logic [SEQ_NUM_W-1:0]           pkt_req_seq_num;
    logic [PAYLOAD_ENTRY_LEN_W-1:0] pkt_req_payload_len;

    logic                           app_head_val;
    logic                           app_head_rdy;
    logic [FLOWID_W-1:0]            app_head_flowid;
    logic [RX_PAYLOAD_IDX_W:0]      app_head_idx;

    logic                           state_rd_req_val;
    logic [FLOWID_W-1:0]            state_rd_req_flowid;
    rx_flow_state_struct            state_rd_resp_data;

    logic                           state_wr_val;
    logic [FLOWID_W-1:0]            state_wr_flowid;
    rx_flow_state_struct            state_wr_data;
    logic                           state_wr_head_only;

    logic                           malloc_req_val;
    logic                           malloc_req_rdy;
    logic [PAYLOAD_ENTRY_LEN_W-1:0] malloc_req_len;
    logic                           malloc_resp_val;
    logic                           malloc_resp_rdy;
    logic                           malloc_resp_success;
    logic [RX_PAYLOAD_PTR_W:0]      malloc_resp_approx_space;

    logic                           result_val;
    logic                           result_rdy;
    logic [FLOWID_W-1:0]            result_flowid;
    logic                           result_accept;
    logic [ACK_NUM_W-1:0]           result_ack_num;
    logic [RX_PAYLOAD_PTR_W:0]      result_our_win;

    modport slave (
        input  pkt_req_val, pkt_req_flowid, pkt_req_seq_num,
        input  pkt_req_payload_len,
        output pkt_req_rdy,
        input  app_head_val, app_head_flowid, app_head_idx,
        output app_head_rdy,
        output state_rd_req_val, state_rd_req_flowid,
        input  state_rd_resp_data,
        output state_wr_val, state_wr_flowid, state_wr_data,
        output state_wr_head_only,
        output malloc_req_val, malloc_req_len,
        input  malloc_req_rdy,
        input  malloc_resp_val, malloc_resp_success,
        input  malloc_resp_approx_space,
        output malloc_resp_rdy,
        output result_val, result_flowid, result_accept,
        output result_ack_num, result_our_win,
        input  result_rdy
    );

    modport master (
        output pkt_req_val, pkt_req_flowid, pkt_req_seq_num,
        output pkt_req_payload_len,
        input  pkt_req_rdy,
        output app_head_val, app_head_flowid, app_head_idx,
        input  app_head_rdy,
        input  state_rd_req_val, state_rd_req_flowid,
        output state_rd_resp_data,
        input  state_wr_val, state_wr_flowid, state_wr_data,
        input  state_wr_head_only,
        input  malloc_req_val, malloc_req_len,
        output malloc_req_rdy,
        output malloc_resp_val, malloc_resp_success,
        output malloc_resp_approx_space,
        input  malloc_resp_rdy,
        input  result_val, result_flowid, result_accept,
        input  result_ack_num, result_our_win,
        output result_rdy
    );

endinterface

// File: rtl/rx_ack_calc.sv
// Combinational accept/ACK/tail/window computation for one packet.
// Ports: st_i state word, seq/len/success/space in; match, full, accept, st_o out.
module rx_ack_calc
    import tcp_pkg::*;
(
    input  rx_flow_state_struct            st_i,
    input  logic [SEQ_NUM_W-1:0]           seq_i,
    input  logic [PAYLOAD_ENTRY_LEN_W-1:0] len_i,
    input  logic                           success_i,
    input  logic [RX_PAYLOAD_PTR_W:0]      space_i,
    output logic                           match_o,
    output logic                           full_o,
    output logic                           accept_o,
    output rx_flow_state_struct            st_o
);

    localparam int SW = RX_PAYLOAD_PTR_W + 1;
    localparam int CW = ((SW > PAYLOAD_ENTRY_LEN_W) ? SW : PAYLOAD_ENTRY_LEN_W) + 1;
    localparam logic [RX_PAYLOAD_IDX_W:0] RING_FULL = {1'b1, {RX_PAYLOAD_IDX_W{1'b0}}};

    logic [RX_PAYLOAD_IDX_W:0] used;
    logic [CW-1:0]             sp_x;
    logic [CW-1:0]             ln_x;
    logic [CW-1:0]             diff;
    logic [SW-1:0]             win_sat;

    // Indices carry one extra wrap bit so full and empty differ.
    assign used     = st_i.tail - st_i.head;
    assign full_o   = (used == RING_FULL);
    assign match_o  = (seq_i == st_i.ack_num);
    assign accept_o = match_o & ~full_o & success_i;

    assign sp_x    = CW'(space_i);
    assign ln_x    = CW'(len_i);
    assign diff    = sp_x - ln_x;
    assign win_sat = (sp_x > ln_x) ? diff[SW-1:0] : '0;

    always_comb begin
        st_o = st_i;
        st_o.last_win = space_i;
        if (accept_o) begin
            st_o.ack_num  = seq_i + ACK_NUM_W'(len_i);
            st_o.tail     = st_i.tail + 1'b1;
            st_o.last_win = win_sat;
        end
    end

endmodule

// File: rtl/rx_flow_state_ctrl.sv
// Per-flow RX state sequencer: read, allocate, update, write back, report.
// Ports: clk, rst (sync, active-high), bus (all handshakes, slave side).
module rx_flow_state_ctrl #(
    parameter int FLOWID_W         = tcp_pkg::FLOWID_W,
    parameter int RX_PAYLOAD_IDX_W = tcp_pkg::RX_PAYLOAD_IDX_W,
    parameter int RX_PAYLOAD_PTR_W = tcp_pkg::RX_PAYLOAD_PTR_W
) (
    input  logic                clk,
    input  logic                rst,
    rx_flow_state_ctrl_if.slave bus
);
    import tcp_pkg::*;

    rx_state_e                      state_q, state_d;
    logic [FLOWID_W-1:0]            flowid_q;
    logic [SEQ_NUM_W-1:0]           seq_q;
    logic [PAYLOAD_ENTRY_LEN_W-1:0] len_q;
    rx_flow_state_struct            st_q;
    logic                           st_vld_q;
    logic                           success_q;
    logic [RX_PAYLOAD_PTR_W:0]      space_q;

    rx_flow_state_struct            st_cur;
    rx_flow_state_struct            st_new;
    rx_flow_state_struct            head_word;
    logic [RX_PAYLOAD_IDX_W:0]      app_idx;
    logic                           match, full, accept;
    logic                           need_malloc;
    logic                           pkt_fire;

    // Read data is only valid in the first DECIDE cycle; later cycles
    // use the latched copy.
    assign st_cur      = st_vld_q ? st_q : bus.state_rd_resp_data;
    assign need_malloc = match & ~full & (len_q != '0);
    assign pkt_fire    = bus.pkt_req_val & bus.pkt_req_rdy;
    assign app_idx     = bus.app_head_idx;

    always_comb begin
        head_word      = '0;
        head_word.head = app_idx;
    end

    rx_ack_calc u_calc (
        .st_i      (st_cur),
        .seq_i     (seq_q),
        .len_i     (len_q),
        .success_i (success_q),
        .space_i   (space_q),
        .match_o   (match),
        .full_o    (full),
        .accept_o  (accept),
        .st_o      (st_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            flowid_q  <= '0;
            seq_q     <= '0;
            len_q     <= '0;
            st_q      <= '0;
            st_vld_q  <= 1'b0;
            success_q <= 1'b0;
            space_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pkt_fire) begin
                flowid_q <= bus.pkt_req_flowid;
                seq_q    <= bus.pkt_req_seq_num;
                len_q    <= bus.pkt_req_payload_len;
                st_vld_q <= 1'b0;
            end
            if (state_q == ST_DECIDE && !st_vld_q) begin
                st_q     <= bus.state_rd_resp_data;
                st_vld_q <= 1'b1;
            end
            if (state_q == ST_DECIDE && !need_malloc) begin
                success_q <= 1'b0;
                space_q   <= st_cur.last_win;
            end
            if (state_q == ST_WAIT_MALLOC && bus.malloc_resp_val) begin
                success_q <= bus.malloc_resp_success;
                space_q   <= bus.malloc_resp_approx_space;
            end
        end
    end

    always_comb begin
        state_d                 = state_q;
        bus.pkt_req_rdy         = 1'b0;
        bus.app_head_rdy        = 1'b0;
        bus.state_rd_req_val    = 1'b0;
        bus.state_rd_req_flowid = '0;
        bus.state_wr_val        = 1'b0;
        bus.state_wr_flowid     = '0;
        bus.state_wr_data       = '0;
        bus.state_wr_head_only  = 1'b0;
        bus.malloc_req_val      = 1'b0;
        bus.malloc_req_len      = '0;
        bus.malloc_resp_rdy     = 1'b0;
        bus.result_val          = 1'b0;
        bus.result_flowid       = '0;
        bus.result_accept       = 1'b0;
        bus.result_ack_num      = '0;
        bus.result_our_win      = '0;

        if (rst) begin
            state_d = ST_IDLE;
        end else begin
            // The write port is free in IDLE and OUT: head updates go there.
            if (state_q == ST_IDLE || state_q == ST_OUT) begin
                bus.app_head_rdy = 1'b1;
                if (bus.app_head_val) begin
                    bus.state_wr_val       = 1'b1;
                    bus.state_wr_head_only = 1'b1;
                    bus.state_wr_flowid    = bus.app_head_flowid;
                    bus.state_wr_data      = head_word;
                end
            end
            if (state_q == ST_WR || state_q == ST_OUT) begin
                bus.result_val     = 1'b1;
                bus.result_flowid  = flowid_q;
                bus.result_accept  = accept;
                bus.result_ack_num = st_new.ack_num;
                bus.result_our_win = st_new.last_win;
            end

            unique case (state_q)
                ST_IDLE: begin
                    bus.pkt_req_rdy = ~bus.app_head_val;
                    if (bus.pkt_req_val && !bus.app_head_val) begin
                        state_d = ST_RD;
                    end
                end
                ST_RD: begin
                    bus.state_rd_req_val    = 1'b1;
                    bus.state_rd_req_flowid = flowid_q;
                    state_d                 = ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (need_malloc) begin
                        bus.malloc_req_val = 1'b1;
                        bus.malloc_req_len = len_q;
                        if (bus.malloc_req_rdy) begin
                            state_d = ST_WAIT_MALLOC;
                        end
                    end else begin
                        state_d = ST_WR;
                    end
                end
                ST_WAIT_MALLOC: begin
                    bus.malloc_resp_rdy = 1'b1;
                    if (bus.malloc_resp_val) begin
                        state_d = ST_WR;
                    end
                end
                ST_WR: begin
                    bus.state_wr_val    = 1'b1;
                    bus.state_wr_flowid = flowid_q;
                    bus.state_wr_data   = st_new;
                    state_d = bus.result_rdy ? ST_IDLE : ST_OUT;
                end
                ST_OUT: begin
                    if (bus.result_rdy) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule
